// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bundle for uart_rx_fifo: FWFT head entry,
// valid/ready pop handshake, occupancy and sticky overrun.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int FIFO_LOG  = 3
);
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
    logic                 valid;
    logic                 ready;
    logic [FIFO_LOG:0]    count;
    logic                 overrun;
    logic                 clr_overrun;

    modport master (
        output data,
        output parity_err,
        output frame_err,
        output valid,
        output count,
        output overrun,
        input  ready,
        input  clr_overrun
    );

    modport slave (
        input  data,
        input  parity_err,
        input  frame_err,
        input  valid,
        input  count,
        input  overrun,
        output ready,
        output clr_overrun
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Parametrised UART receiver with false-start rejection, per-character
// parity/framing flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
    parameter int CLK_CYCLES = 4167,
    parameter int CTR_WIDTH  = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_LOG   = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          uart_rx,
    uart_rx_fifo_if.master host
);
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam int W     = DATA_BITS + 2;

    localparam logic [CTR_WIDTH-1:0] CTR_HALF =
        CTR_WIDTH'(CLK_CYCLES / 2 - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_FULL =
        CTR_WIDTH'(CLK_CYCLES - 1);
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BREAK
    } state_t;

    logic                 rx_meta;
    logic                 rxs;
    state_t               state;
    logic [CTR_WIDTH-1:0] ctr;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr;
    logic                 ferr;

    logic [W-1:0]         mem [DEPTH];
    logic [FIFO_LOG-1:0]  wr_ptr;
    logic [FIFO_LOG-1:0]  rd_ptr;
    logic [FIFO_LOG:0]    cnt;
    logic                 ovr;

    logic                 tick;
    logic                 push;
    logic [W-1:0]         push_word;
    logic                 valid;
    logic                 full;
    logic                 pop;
    logic                 accept;
    logic [W-1:0]         head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rxs     <= rx_meta;
        end
    end

    assign tick = (ctr == '0);
    assign push = (state == STOP) && tick &&
                  (bit_cnt == LAST_STOP);
    // The final stop sample folds straight into the pushed flags.
    assign push_word = {perr, ferr | ~rxs, shreg};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ctr     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        ctr   <= CTR_HALF;
                        state <= START;
                    end
                end
                START: begin
                    if (!tick) begin
                        ctr <= ctr - 1'b1;
                    end else if (rxs) begin
                        state <= IDLE;
                    end else begin
                        ctr     <= CTR_FULL;
                        bit_cnt <= '0;
                        perr    <= 1'b0;
                        ferr    <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (!tick) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        ctr   <= CTR_FULL;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PAR: begin
                    if (!tick) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        ctr   <= CTR_FULL;
                        perr  <= ((^shreg) ^ rxs) != ODD;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (!tick) begin
                        ctr <= ctr - 1'b1;
                    end else begin
                        ctr  <= CTR_FULL;
                        ferr <= ferr | ~rxs;
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            state   <= rxs ? IDLE : BREAK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign valid  = (cnt != '0);
    assign full   = (cnt == (FIFO_LOG+1)'(DEPTH));
    assign pop    = valid && host.ready;
    assign accept = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovr    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (push && !accept) begin
                ovr <= 1'b1;
            end else if (host.clr_overrun) begin
                ovr <= 1'b0;
            end
        end
    end

    // Head is masked so stale memory never shows while empty.
    assign head            = valid ? mem[rd_ptr] : '0;
    assign host.data       = head[DATA_BITS-1:0];
    assign host.frame_err  = head[DATA_BITS];
    assign host.parity_err = head[DATA_BITS+1];
    assign host.valid      = valid;
    assign host.count      = cnt;
    assign host.overrun    = ovr;
endmodule
